div_seq: RTL

- Sequential restoring radix-2 divider: unsigned N-bit dividend / N-bit divisor → N-bit quotient + N-bit remainder.
- One quotient bit per clock.
- Inverse companion of the sequential CLA multiplier; same start/valid handshake so datapath control drives both alike.

---
 rtl/div_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: sequential restoring radix-2 divider, one quotient bit per clock.
// Unsigned N-bit dividend / divisor -> N-bit quotient + remainder with a
// start/valid handshake shared with the sequential multiplier.
//
// Optional build macro: SIGNED_DIV_EN
//   defined   -> operands are two's complement; quotient truncates toward
//                zero and the remainder takes the dividend's sign.
//   undefined -> unsigned only; no sign logic is built.
//
// Handshake: start is sampled on a rising edge only while the FSM is IDLE;
// that edge captures dividend/divisor, after which the inputs may change.
// valid is a one-cycle pulse in the cycle quotient/remainder/div_by_zero
// change. busy is high from the accepting edge through the valid cycle.
// state_dbg exposes the FSM state (IDLE=0, RUN=1, DONE=2).
`timescale 1ns/1ps

module div_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         valid,
    output logic         busy,
    output logic         div_by_zero,
    output logic [1:0]   state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CW = $clog2(N + 1);

    // Control and datapath state
    logic [1:0]   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] r_q, r_d;         // partial remainder
    logic [N-1:0] q_q, q_d;         // dividend shifting out / quotient shifting in
    logic [N-1:0] dvs_q, dvs_d;     // captured divisor (magnitude)
    logic         zdiv_q, zdiv_d;   // captured divisor was zero

    // Registered outputs
    logic [N-1:0] quotient_q, quotient_d;
    logic [N-1:0] remainder_q, remainder_d;
    logic         valid_q, valid_d;
    logic         div_by_zero_q, div_by_zero_d;

`ifdef SIGNED_DIV_EN
    logic         sa_q, sa_d;       // dividend sign
    logic         sb_q, sb_d;       // divisor sign
`endif

    // Operand magnitudes presented to the unsigned core
    logic [N-1:0] dividend_mag;
    logic [N-1:0] divisor_mag;

    // One restoring step: {R,Q} << 1, then trial subtract of the divisor
    logic [N:0]   r_sh;
    logic         fits;
    logic [N-1:0] r_sub;

    // Operand conditioning and the single-step trial subtraction
    always_comb begin
`ifdef SIGNED_DIV_EN
        dividend_mag = dividend[N-1] ? (~dividend + 1'b1) : dividend;
        divisor_mag  = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
`else
        dividend_mag = dividend;
        divisor_mag  = divisor;
`endif
        r_sh  = {r_q, q_q[N-1]};
        // T = r_sh - divisor in N+1 bits is non-negative exactly when r_sh >= divisor;
        // in that case T < divisor, so the low N bits hold it completely.
        fits  = (r_sh >= {1'b0, dvs_q});
        r_sub = r_sh[N-1:0] - dvs_q;
    end

    // Next-state and next-output logic for IDLE / RUN / DONE
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        r_d           = r_q;
        q_d           = q_q;
        dvs_d         = dvs_q;
        zdiv_d        = zdiv_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        valid_d       = 1'b0;
        div_by_zero_d = div_by_zero_q;
`ifdef SIGNED_DIV_EN
        sa_d          = sa_q;
        sb_d          = sb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvs_d = divisor_mag;
                    r_d   = '0;
                    cnt_d = CW'(N);
`ifdef SIGNED_DIV_EN
                    sa_d  = dividend[N-1];
                    sb_d  = divisor[N-1];
`endif
                    if (divisor == '0) begin
                        // Keep the raw dividend: it becomes the remainder.
                        zdiv_d  = 1'b1;
                        q_d     = dividend;
                        state_d = ST_DONE;
                    end else begin
                        zdiv_d  = 1'b0;
                        q_d     = dividend_mag;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_d   = fits ? r_sub : r_sh[N-1:0];
                q_d   = {q_q[N-2:0], fits};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
                if (zdiv_q) begin
                    quotient_d    = '1;
                    remainder_d   = q_q;
                    div_by_zero_d = 1'b1;
                end else begin
`ifdef SIGNED_DIV_EN
                    quotient_d    = (sa_q ^ sb_q) ? (~q_q + 1'b1) : q_q;
                    remainder_d   = sa_q ? (~r_q + 1'b1) : r_q;
`else
                    quotient_d    = q_q;
                    remainder_d   = r_q;
`endif
                    div_by_zero_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any division in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            r_q           <= '0;
            q_q           <= '0;
            dvs_q         <= '0;
            zdiv_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            valid_q       <= 1'b0;
            div_by_zero_q <= 1'b0;
`ifdef SIGNED_DIV_EN
            sa_q          <= 1'b0;
            sb_q          <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            r_q           <= r_d;
            q_q           <= q_d;
            dvs_q         <= dvs_d;
            zdiv_q        <= zdiv_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            valid_q       <= valid_d;
            div_by_zero_q <= div_by_zero_d;
`ifdef SIGNED_DIV_EN
            sa_q          <= sa_d;
            sb_q          <= sb_d;
`endif
        end
    end

    // busy covers RUN, DONE and the valid cycle that follows DONE
    always_comb begin
        busy = (state_q != ST_IDLE) || valid_q;
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign valid       = valid_q;
    assign div_by_zero = div_by_zero_q;
    assign state_dbg   = state_q;

endmodule
